pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central hazard and redirect controller for the 5-stage pipelined RV32 CPU. Resolves taken branches/jumps from MEM-stage flags, detects EX-stage load-use hazards, and tracks instruction-memory stalls. Drives PC write, pipeline-register enables and flushes. Sits beside the datapath and replaces the scattered per-stage PCSrc/stall glue; also exposes hazard performance counters.

## Interface
- CNT_W, 16, width of each performance counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Branch_in_Mem  in  1  beq-type branch in MEM
- BranchN_in_Mem  in  1  bne-type branch in MEM
- zero_in_Mem  in  1  ALU zero flag of the MEM instruction
- Jump_in_Mem  in  2  bit0 jal, bit1 jalr, in MEM
- MemRead_in_Ex  in  1  EX instruction is a load
- Rd_in_Ex  in  5  EX destination register
- Rs1_in_ID, Rs2_in_ID  in  5 each  ID source registers
- Rs1_used_ID, Rs2_used_ID  in  1 each  ID instruction reads rs1/rs2
- imem_ready  in  1  instruction for current PC is available this cycle
- PCSrc  out  1  select branch/jump target for PC
- PCWrite  out  1  PC load enable
- IF_ID_en  out  1  IF/ID register load enable
- IF_ID_flush, ID_EX_flush, EX_MEM_flush  out  1 each  load bubble (NOP, all control zero) into that register
- stall_cnt, flush_cnt, ifbub_cnt  out  CNT_W each  performance counters

## Operation
- taken = Jump_in_Mem[0] | Jump_in_Mem[1] | (Branch_in_Mem & zero_in_Mem) | (BranchN_in_Mem & ~zero_in_Mem).
- load_use = MemRead_in_Ex & (Rd_in_Ex != 0) & ((Rs1_used_ID & Rs1_in_ID == Rd_in_Ex) | (Rs2_used_ID & Rs2_in_ID == Rd_in_Ex)).
- Two states: RUN, DISCARD. All outputs are combinational from state and inputs; state and counters are registered.
- Default (no event): PCWrite=1, IF_ID_en=1, all flushes 0, PCSrc=0.
- RUN, priority highest first:
  - taken: PCSrc=1, PCWrite=1, IF_ID_flush=ID_EX_flush=EX_MEM_flush=1; load_use ignored; flush_cnt+1. Next state DISCARD if imem_ready=0, else RUN.
  - load_use: PCWrite=0, IF_ID_en=0, ID_EX_flush=1; stall_cnt+1; imem_ready ignored.
  - imem_ready=0: PCWrite=0, IF_ID_flush=1 (bubble into ID, older stages advance); ifbub_cnt+1.
  - else default.
- DISCARD: the fetch outstanding at redirect is stale. PCWrite=0, IF_ID_flush=1 every cycle; ifbub_cnt+1 every cycle. Branch/jump and load-use inputs ignored (front end holds only bubbles). First cycle with imem_ready=1 consumes the stale response and returns to RUN; the fetch for the target PC starts the next cycle.
- Flush has precedence over enable in the same register.
- Counters wrap modulo 2^CNT_W; no saturation.

## Timing
- Reset (rst_n low, asynchronous): state=RUN, counters=0. While rst_n is low: PCWrite=0, IF_ID_en=0, all flushes 1, PCSrc=0.
- Release: the first rising edge with rst_n high is normal RUN operation.
- Redirect latency: PC holds the target one edge after taken is seen in MEM; 3-cycle branch penalty (IF/ID, ID/EX, EX/MEM squashed).
- Load-use: exactly one bubble per hazard. On the next cycle ID/EX holds a bubble, so the hazard clears; forwarding covers the rest.
- Simultaneous taken + load_use: redirect wins; no stall, stall_cnt unchanged.
- Simultaneous taken + imem_ready=0: PC still loads target that cycle; stale fetch discarded via DISCARD.
- Reset mid-DISCARD: returns to RUN immediately; the stale response after reset is not filtered (imem is reset together).

## Test plan
- Reset: hold rst_n=0 with random inputs -> PCWrite=0, IF_ID_en=0, three flushes 1, counters 0; release -> default outputs with imem_ready=1 and no hazards.
- beq taken: Branch_in_Mem=1, zero=1, imem_ready=1 for one cycle -> PCSrc=1, PCWrite=1, three flushes 1 that cycle, flush_cnt=1, state stays RUN; bne with zero=1 -> no redirect.
- Load-use: MemRead_in_Ex=1, Rd_in_Ex=5, Rs2_in_ID=5, Rs2_used_ID=1 for one cycle -> PCWrite=0, IF_ID_en=0, ID_EX_flush=1, stall_cnt=1; repeat with Rd_in_Ex=0 -> no stall.
- Redirect during fetch stall: jal (Jump=2'b01) with imem_ready=0, then imem_ready=0 for 2 cycles, then 1 -> PCWrite=1 redirect cycle, DISCARD 3 cycles with IF_ID_flush=1, PCWrite=0, then RUN; ifbub_cnt=3.
- Priority: taken and load_use together -> redirect outputs, ID_EX_flush=1, IF_ID_en=1, stall_cnt unchanged.
- Wrap: CNT_W=4, 17 load-use cycles -> stall_cnt=1.

Source files
------------

// File: rtl/hazard_if.sv
// Hazard-controller bundle: pipeline-stage hazard flags in, PC/pipeline-register
// controls and performance counters out.
interface hazard_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             Branch_in_Mem;
  logic             BranchN_in_Mem;
  logic             zero_in_Mem;
  logic [1:0]       Jump_in_Mem;
  logic             MemRead_in_Ex;
  logic [4:0]       Rd_in_Ex;
  logic [4:0]       Rs1_in_ID;
  logic [4:0]       Rs2_in_ID;
  logic             Rs1_used_ID;
  logic             Rs2_used_ID;
  logic             imem_ready;

  logic             PCSrc;
  logic             PCWrite;
  logic             IF_ID_en;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] ifbub_cnt;

  // Datapath side: drives stage flags, consumes controls.
  modport master (
    output Branch_in_Mem, BranchN_in_Mem, zero_in_Mem, Jump_in_Mem,
           MemRead_in_Ex, Rd_in_Ex, Rs1_in_ID, Rs2_in_ID,
           Rs1_used_ID, Rs2_used_ID, imem_ready,
    input  PCSrc, PCWrite, IF_ID_en, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
           stall_cnt, flush_cnt, ifbub_cnt
  );

  // Controller side.
  modport slave (
    input  Branch_in_Mem, BranchN_in_Mem, zero_in_Mem, Jump_in_Mem,
           MemRead_in_Ex, Rd_in_Ex, Rs1_in_ID, Rs2_in_ID,
           Rs1_used_ID, Rs2_used_ID, imem_ready,
    output PCSrc, PCWrite, IF_ID_en, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
           stall_cnt, flush_cnt, ifbub_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central redirect / load-use / fetch-stall controller for the 5-stage RV32 pipeline.
// Controls are combinational from state and stage flags; state and counters are registered.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] ifbub_cnt_q, ifbub_cnt_d;

  logic taken_c;
  logic rs1_hit_c;
  logic rs2_hit_c;
  logic load_use_c;

  logic pc_src_c;
  logic pc_write_c;
  logic if_id_en_c;
  logic if_id_flush_c;
  logic id_ex_flush_c;
  logic ex_mem_flush_c;
  logic stall_inc_c;
  logic flush_inc_c;
  logic ifbub_inc_c;

  // Hazard detection from stage flags.
  always_comb begin
    taken_c    = hz.Jump_in_Mem[0] | hz.Jump_in_Mem[1]
               | (hz.Branch_in_Mem  &  hz.zero_in_Mem)
               | (hz.BranchN_in_Mem & ~hz.zero_in_Mem);
    rs1_hit_c  = hz.Rs1_used_ID & (hz.Rs1_in_ID == hz.Rd_in_Ex);
    rs2_hit_c  = hz.Rs2_used_ID & (hz.Rs2_in_ID == hz.Rd_in_Ex);
    load_use_c = hz.MemRead_in_Ex & (hz.Rd_in_Ex != 5'd0) & (rs1_hit_c | rs2_hit_c);
  end

  // Next-state and control outputs.
  always_comb begin
    state_d        = state_q;
    pc_src_c       = 1'b0;
    pc_write_c     = 1'b1;
    if_id_en_c     = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    stall_inc_c    = 1'b0;
    flush_inc_c    = 1'b0;
    ifbub_inc_c    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (taken_c) begin
          pc_src_c       = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_flush_c  = 1'b1;
          ex_mem_flush_c = 1'b1;
          flush_inc_c    = 1'b1;
          // The fetch in flight for the old PC must be thrown away when it lands.
          if (!hz.imem_ready) state_d = ST_DISCARD;
        end else if (load_use_c) begin
          pc_write_c    = 1'b0;
          if_id_en_c    = 1'b0;
          id_ex_flush_c = 1'b1;
          stall_inc_c   = 1'b1;
        end else if (!hz.imem_ready) begin
          pc_write_c    = 1'b0;
          if_id_flush_c = 1'b1;
          ifbub_inc_c   = 1'b1;
        end
      end
      ST_DISCARD: begin
        pc_write_c    = 1'b0;
        if_id_flush_c = 1'b1;
        ifbub_inc_c   = 1'b1;
        if (hz.imem_ready) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Hold the whole pipeline in bubbles while reset is asserted.
    if (!rst_n) begin
      pc_src_c       = 1'b0;
      pc_write_c     = 1'b0;
      if_id_en_c     = 1'b0;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
      ex_mem_flush_c = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_inc_c);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_inc_c);
    ifbub_cnt_d = ifbub_cnt_q + CNT_W'(ifbub_inc_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      ifbub_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ifbub_cnt_q <= ifbub_cnt_d;
    end
  end

  assign hz.PCSrc        = pc_src_c;
  assign hz.PCWrite      = pc_write_c;
  assign hz.IF_ID_en     = if_id_en_c;
  assign hz.IF_ID_flush  = if_id_flush_c;
  assign hz.ID_EX_flush  = id_ex_flush_c;
  assign hz.EX_MEM_flush = ex_mem_flush_c;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;
  assign hz.ifbub_cnt    = ifbub_cnt_q;

endmodule
